// File: rtl/axi4_burst_ram.sv
// axi4_burst_ram: AXI4 slave RAM with byte strobes and independent FIXED/INCR/WRAP read and write burst engines.
module axi4_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int WB    = $clog2(STRB_WIDTH);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - WB);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                      input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc, mask;
    logic wrap;
    inc  = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap = burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return burst == 2'b00 ? a : wrap ? (a & ~mask) | ((a + inc) & mask) : a + inc;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, we;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [7:0] wcnt_q, wcnt_d, wlen_q, wlen_d, rcnt_q, rcnt_d, rlen_q, rlen_d;
  logic [2:0] wsize_q, wsize_d, rsize_q, rsize_d;
  logic [1:0] wburst_q, wburst_d, rburst_q, rburst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic unused_wlast;

  assign unused_wlast  = s_axi_wlast;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wcnt_d    = wcnt_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    we        = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = s_axi_awid;
          waddr_d   = s_axi_awaddr;
          wcnt_d    = s_axi_awlen;
          wlen_d    = s_axi_awlen;
          wsize_d   = s_axi_awsize;
          wburst_d  = s_axi_awburst;
          w_state_d = W_DATA;
        end
      end
      W_DATA: if (s_axi_wvalid && wready_q) begin
        we      = 1'b1;
        waddr_d = step_addr(waddr_q, wlen_q, wsize_q, wburst_q);
        wcnt_d  = wcnt_q - 8'd1;
        if (wcnt_q == 8'd0) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (s_axi_bready && bvalid_q) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // rdata is loaded from the array before this edge's write lands, so same-edge reads see old data
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = s_axi_arlen == 8'd0;
          rid_d     = s_axi_arid;
          rdata_d   = mem[s_axi_araddr[ADDR_WIDTH-1:WB]];
          raddr_d   = step_addr(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
          rcnt_d    = s_axi_arlen;
          rlen_d    = s_axi_arlen;
          rsize_d   = s_axi_arsize;
          rburst_d  = s_axi_arburst;
          r_state_d = R_DATA;
        end
      end
      R_DATA: if (rvalid_q && s_axi_rready) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rdata_d = mem[raddr_q[ADDR_WIDTH-1:WB]];
          raddr_d = step_addr(raddr_q, rlen_q, rsize_q, rburst_q);
          rcnt_d  = rcnt_q - 8'd1;
          rlast_d = rcnt_q == 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wcnt_q    <= wcnt_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++)
      if (rst_n && we && s_axi_wstrb[i]) mem[waddr_q[ADDR_WIDTH-1:WB]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  end
endmodule

// File: doc/axi4_burst_ram.md
Name: axi4_burst_ram

Overview:
- AXI4 slave memory endpoint that consumes the master port (m00_axi_*) of the 1x1 AXI4 interconnect.
- Implements a byte-strobed RAM of 2**(ADDR_WIDTH-log2(STRB_WIDTH)) words.
- Independent read and write burst engines: FIXED, INCR and WRAP bursts, one beat per cycle, registered read data.
- Used as on-chip SoC RAM behind the interconnect.

Parameters:
DATA_WIDTH, 32, data bus width (bits); multiple of 8
ADDR_WIDTH, 16, byte address width; sets memory depth
STRB_WIDTH, DATA_WIDTH/8, write strobe width
ID_WIDTH, 8, AXI ID width; IDs returned unchanged

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  log2 bytes per beat (<= log2 STRB_WIDTH)
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STRB_WIDTH  byte enables
s_axi_wlast  in  1  ignored; beat count governs
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bid  out  ID_WIDTH  latched awid
s_axi_bresp  out  2  always 2'b00
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  as AW  read address channel
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rid  out  ID_WIDTH  latched arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  always 2'b00
s_axi_rlast  out  1  final beat
s_axi_rvalid / s_axi_rready  out/in  1  R handshake

Behaviour:
- Only clk drives state. rst_n is sampled on clk; rst_n=0 at an edge resets.
- Reset values: all valid/ready outputs 0, bid/rid/rdata/resp 0, both FSMs IDLE. Memory contents are not reset.
- First cycle after release: awready=arready=1.
- Reset mid-burst aborts the burst. No B/R beat is issued for it. Partial writes already committed remain.
- Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. Upper address bits beyond the memory depth do not exist, so there is no aliasing or decode error.
- Address step per beat:
  - FIXED: none.
  - INCR: addr += 1<<size.
  - WRAP: mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr + (1<<size)) & mask). Valid only for len in {1,3,7,15}; otherwise behaves as INCR.
- Write FSM, IDLE -> WRITE -> RESP -> IDLE:
  - IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, set beat counter = awlen, drop awready; next cycle WRITE.
  - WRITE: wready=1. Each W handshake writes bytes where wstrb[i]=1 at the current word, then steps the address. When the handshake happens with counter==0, deassert wready and go to RESP with bvalid=1.
  - RESP: hold bvalid/bid/bresp stable until bready; then IDLE with awready=1 next cycle.
- Read FSM, IDLE -> READ -> IDLE:
  - IDLE: arready=1. On AR handshake, latch fields and register mem[first word] into rdata; next cycle rvalid=1, rlast=(arlen==0). Latency: AR handshake to first rvalid is 1 cycle.
  - READ: while rvalid && !rready, rdata/rid/rlast hold stable. On R handshake with beats remaining, rdata loads the next word in the same edge, so continuous rready gives one beat per cycle.
  - R handshake with rlast: rvalid=0, IDLE, arready=1 next cycle.
- Concurrency: read and write engines run concurrently. A read of a word written at the same clock edge returns the old value.
- Write width: a 256-beat burst (len=255) is legal; beat counters are 8 bits.

Test Plan:
1. Single write then read: AW 0x1000 id 0x5 len 0; W 0xDEADBEEF strb 0xF -> bvalid, bresp 0, bid 0x5. AR 0x1000 id 0x3 -> one cycle later rdata 0xDEADBEEF, rlast=1, rid 0x3.
2. INCR len=3 write at 0x20 with data 1,2,3,4, then INCR read len=3 with rready held 1 -> beats 1,2,3,4 in 4 consecutive cycles, rlast only on the 4th.
3. Strobes: write 0x11223344 strb 0xF, then 0xAABBCCDD strb 0x5, same address -> read returns 0x11BB33DD.
4. WRAP len=3 size=2 start 0x38 with data A,B,C,D -> FIXED reads of 0x30,0x34,0x38,0x3C return C,D,A,B.
5. Backpressure:
   - Read: toggle rready every other cycle during a len=7 read -> rdata never changes while rvalid && !rready; all 8 beats correct.
   - Write: hold bready=0 for 10 cycles -> bvalid stays 1, awready stays 0.
6. Reset mid-burst: rst_n=0 for 1 cycle after beat 2 of a len=7 write -> next cycle bvalid=0, wready=0, awready=1. Re-reading the first two beats shows their data committed.
